clk_div_ctrl: RTL
=================

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of half-period counter and config value.
REQ-002 Parameter DEFAULT_HALF, default 104166, half-period count loaded at reset (100 MHz / (2*480)).
REQ-003 clk_in  input  1  system clock, 100 MHz; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cfg_half  input  CNT_W  requested half-period, in clk_in cycles.
REQ-006 cfg_valid  input  1  cfg_half offered this cycle.
REQ-007 cfg_ready  output  1  controller can accept cfg_half; transfer when cfg_valid && cfg_ready.
REQ-008 run  input  1  level request to generate clk_out.
REQ-009 burst_len  input  16  rising edges to generate per run; 0 = continuous; sampled on IDLE->RUN.
REQ-010 clk_out  output  1  divided clock, registered, glitch-free.
REQ-011 tick  output  1  one-cycle pulse in the first cycle clk_out reads 1.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  one-cycle pulse on burst completion.

Function
REQ-014 States SHALL be IDLE, RUN, PEND (RUN with a config value waiting to be applied).
REQ-015 IDLE: clk_out held 0, cnt held 0; run=1 -> RUN next cycle, edge counter cleared, burst_len latched.
REQ-016 IDLE: accepted config SHALL write half_reg directly next cycle; cfg_ready stays 1.
REQ-017 RUN/PEND: cnt increments each cycle; at cnt == half_reg-1, clk_out toggles and cnt returns to 0; period = 2*half_reg cycles, 50% duty.
REQ-018 First clk_out rise SHALL occur half_reg cycles after entering RUN.
REQ-019 Accepted cfg_half of 0 SHALL be stored as 1; no other clamping.
REQ-020 RUN: config accepted -> captured into pend_reg, state PEND; cfg_ready = 0 in PEND.
REQ-021 PEND: pend_reg SHALL be copied to half_reg at the next 1->0 toggle of clk_out, cnt = 0, state RUN; cfg_ready = 1 the following cycle.
REQ-022 Config accepted in the same cycle as a 1->0 toggle SHALL NOT apply at that toggle; applies at the next falling toggle.
REQ-023 Rising-edge counter (16 bits) increments on each 0->1 toggle; when burst_len != 0 and count == burst_len, the following 1->0 toggle SHALL end the burst: state IDLE, done = 1 for that one cycle.
REQ-024 run = 0 while clk_out = 0: state IDLE next cycle, clk_out stays 0, no done.
REQ-025 run = 0 while clk_out = 1: high phase completes at normal boundary, then IDLE; no high pulse shorter than half_reg cycles ever.
REQ-026 Any transition to IDLE from PEND SHALL apply pend_reg to half_reg in the same cycle.
REQ-027 run held 1 after burst completion SHALL NOT restart until run is seen 0 for at least one cycle.
REQ-028 busy and cfg_ready SHALL be registered-state functions only (no combinational path from inputs).

Reset
REQ-029 reset = 1 at a clk_in edge SHALL, next cycle: state IDLE, half_reg = DEFAULT_HALF, pend_reg discarded, cnt = 0, edge count = 0, clk_out = 0, tick = 0, done = 0, busy = 0, cfg_ready = 1.
REQ-030 reset SHALL take priority over run, cfg_valid and all in-progress toggles, including mid-RUN/PEND.

Verification
REQ-031 DEFAULT_HALF=4, run=1 from reset -> clk_out rises 4 cycles after busy, period 8, tick once per period, burst_len=0 runs indefinitely.
REQ-032 half_reg=4, cfg_half=2 offered during high phase -> cfg_ready drops, current high completes at 4 cycles, subsequent periods 4 cycles, cfg_ready returns 1 cycle after switch.
REQ-033 half_reg=2, burst_len=3 -> exactly 3 tick pulses, done one cycle coincident with IDLE entry after third falling edge, busy low, clk_out 0.
REQ-034 run dropped on first high cycle -> clk_out high full half_reg cycles then IDLE; run dropped mid-low -> IDLE next cycle, clk_out never rises.
REQ-035 cfg_half=0 accepted in IDLE, then run -> clk_out toggles every cycle (period 2), tick every 2 cycles.
REQ-036 reset pulsed while PEND with pending value 7 -> next cycle all outputs at reset values, half_reg = DEFAULT_HALF, value 7 never applied.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable 50% duty clock divider with burst mode and glitch-free reconfiguration
module clk_div_ctrl #(
    parameter int CNT_W        = 32,
    parameter int DEFAULT_HALF = 104166
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             run,
    input  logic [15:0]      burst_len,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
    state_t state, state_n;
    logic [CNT_W-1:0] half_reg, pend_reg, cnt, cfg_val;
    logic [15:0] edge_cnt, blen;
    logic stop_req, lock, toggle, rise, fall, finish, stop, cfg_acc;
    assign busy      = state != IDLE;
    assign cfg_ready = state != PEND;
    always_comb begin
        cfg_acc = cfg_valid && cfg_ready;
        cfg_val = (cfg_half == '0) ? CNT_W'(1) : cfg_half;
        toggle  = busy && (cnt == half_reg - CNT_W'(1));
        rise    = toggle && !clk_out;
        fall    = toggle && clk_out;
        finish  = fall && (blen != 16'd0) && (edge_cnt == blen);
        // a high phase always runs to its natural falling boundary before stopping
        stop    = busy && ((!run && !clk_out) || (fall && (stop_req || !run)) || finish);
        state_n = state;
        if (state == IDLE)
            state_n = (run && !lock) ? RUN : IDLE;
        else if (stop)
            state_n = IDLE;
        else if (state == RUN)
            state_n = cfg_acc ? PEND : RUN;
        else
            state_n = fall ? RUN : PEND;
    end
    always_ff @(posedge clk_in) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end
    always_ff @(posedge clk_in) begin
        if (reset) begin
            half_reg <= CNT_W'(DEFAULT_HALF);
            pend_reg <= '0;
            cnt      <= '0;
            edge_cnt <= '0;
            blen     <= '0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            done     <= 1'b0;
            stop_req <= 1'b0;
            lock     <= 1'b0;
        end else begin
            tick     <= rise && run;
            done     <= finish;
            lock     <= finish || (lock && run);
            stop_req <= busy && (stop_req || (clk_out && !run)) && state_n != IDLE;
            // a config arriving as the run ends has no later falling edge, so it lands directly
            if (cfg_acc && (state == IDLE || stop))
                half_reg <= cfg_val;
            else if (state == PEND && (fall || stop))
                half_reg <= pend_reg;
            if (cfg_acc && state == RUN)
                pend_reg <= cfg_val;
            if (state == IDLE || state_n == IDLE) begin
                cnt     <= '0;
                clk_out <= 1'b0;
            end else if (toggle) begin
                cnt     <= '0;
                clk_out <= !clk_out;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (state == IDLE) begin
                edge_cnt <= '0;
                blen     <= burst_len;
            end else if (rise && run) begin
                edge_cnt <= edge_cnt + 16'd1;
            end
        end
    end
endmodule
